// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, widths and parity helper
package uart_pkg;

  localparam int BAUD_DIV_W = 12;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

  // Parity bit that makes XOR(data, p) equal to the odd/even selector.
  function automatic logic parity_calc(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/fifo_simple.sv
// rtl/fifo_simple.sv - first-word fall-through FIFO with wrap-bit pointers
module fifo_simple #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [W-1:0] wdata,
  input  logic         re,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;
  logic         do_rd, do_wr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_rd = re && !empty;
  assign do_wr = we && (!full || do_rd);
  assign rdata = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_wr) wptr <= wptr + PTR_ONE;
      if (do_rd) rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling 8N1/8E1/8O1 deserialiser with parity and stop checks
module uart_rx
  import uart_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic [BAUD_DIV_W-1:0] baud_divider,
  input  logic                  parity_en,
  input  logic                  parity_type_odd,
  output logic                  valid,
  output logic [7:0]            byte_o,
  output logic                  perr,
  output logic                  ferr
);
  localparam logic [BAUD_DIV_W-1:0] CNT_ONE = 1;

  rx_state_t             state;
  logic                  rx_meta, rxs, rxs_d, armed;
  logic [1:0]            fill;
  logic [BAUD_DIV_W-1:0] div_q, cnt;
  logic                  par_en_q, par_odd_q, par_bit;
  logic [2:0]            bit_idx;
  logic [7:0]            sreg;
  logic                  tick;

  assign tick   = (cnt == '0);
  assign byte_o = sreg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta   <= 1'b1;
      rxs       <= 1'b1;
      rxs_d     <= 1'b1;
      fill      <= 2'b00;
      armed     <= 1'b0;
      state     <= IDLE;
      div_q     <= '0;
      cnt       <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      par_bit   <= 1'b0;
      bit_idx   <= '0;
      sreg      <= '0;
      valid     <= 1'b0;
      perr      <= 1'b0;
      ferr      <= 1'b0;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
      fill    <= {fill[0], 1'b1};
      valid   <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      // Arm only once rxs carries a real line sample, not its reset value.
      if (fill[1] && rxs) armed <= 1'b1;

      case (state)
        IDLE: begin
          if (armed && rxs_d && !rxs) begin
            div_q     <= baud_divider;
            par_en_q  <= parity_en;
            par_odd_q <= parity_type_odd;
            cnt       <= (baud_divider >> 1) - CNT_ONE;
            state     <= START;
          end
        end
        START: begin
          if (tick) begin
            if (rxs) begin
              state <= IDLE;
            end else begin
              cnt     <= div_q - CNT_ONE;
              bit_idx <= '0;
              state   <= DATA;
            end
          end else cnt <= cnt - CNT_ONE;
        end
        DATA: begin
          if (tick) begin
            sreg    <= {rxs, sreg[7:1]};
            cnt     <= div_q - CNT_ONE;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= par_en_q ? PARITY : STOP;
          end else cnt <= cnt - CNT_ONE;
        end
        PARITY: begin
          if (tick) begin
            par_bit <= rxs;
            cnt     <= div_q - CNT_ONE;
            state   <= STOP;
          end else cnt <= cnt - CNT_ONE;
        end
        STOP: begin
          if (tick) begin
            state <= IDLE;
            if (!rxs) begin
              ferr  <= 1'b1;
              armed <= 1'b0;
            end else if (par_en_q && (par_bit != parity_calc(sreg, par_odd_q))) begin
              perr <= 1'b1;
            end else begin
              valid <= 1'b1;
            end
          end else cnt <= cnt - CNT_ONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_buffered_rx.sv
// rtl/uart_buffered_rx.sv - UART receiver feeding a FWFT FIFO with sticky error flags
module uart_buffered_rx
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  re,
  output logic [7:0]            data,
  output logic                  buffer_empty,
  output logic                  buffer_full,
  input  logic                  rx,
  input  logic [BAUD_DIV_W-1:0] baud_divider,
  input  logic                  parity_en,
  input  logic                  parity_type_odd,
  input  logic                  err_clear,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun
);
  logic       rx_valid, rx_perr, rx_ferr, drop_full;
  logic [7:0] rx_byte;

  uart_rx u_rx (
    .clk             (clk),
    .rst             (rst),
    .rx              (rx),
    .baud_divider    (baud_divider),
    .parity_en       (parity_en),
    .parity_type_odd (parity_type_odd),
    .valid           (rx_valid),
    .byte_o          (rx_byte),
    .perr            (rx_perr),
    .ferr            (rx_ferr)
  );

  // A same-cycle pop frees the slot, so a full FIFO only drops without re.
  assign drop_full = rx_valid && buffer_full && !re;

  fifo_simple #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .we    (rx_valid && !drop_full),
    .wdata (rx_byte),
    .re    (re),
    .rdata (data),
    .empty (buffer_empty),
    .full  (buffer_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (rx_perr)        parity_err <= 1'b1;
      else if (err_clear) parity_err <= 1'b0;
      if (rx_ferr)        frame_err  <= 1'b1;
      else if (err_clear) frame_err  <= 1'b0;
      if (drop_full)      overrun    <= 1'b1;
      else if (err_clear) overrun    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_buffered_rx.sv
// tb/tb_uart_buffered_rx.sv - scoreboard bench for uart_buffered_rx
module tb_uart_buffered_rx;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        re = 1'b0;
  logic        rx = 1'b1;
  logic [11:0] baud_divider = 12'd16;
  logic        parity_en = 1'b0;
  logic        parity_type_odd = 1'b0;
  logic        err_clear = 1'b0;
  logic [7:0]  data;
  logic        buffer_empty, buffer_full, parity_err, frame_err, overrun;

  int          n_checks = 0;
  int          n_errors = 0;
  int          lat_cyc;
  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  uart_buffered_rx #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .re              (re),
    .data            (data),
    .buffer_empty    (buffer_empty),
    .buffer_full     (buffer_full),
    .rx              (rx),
    .baud_divider    (baud_divider),
    .parity_en       (parity_en),
    .parity_type_odd (parity_type_odd),
    .err_clear       (err_clear),
    .parity_err      (parity_err),
    .frame_err       (frame_err),
    .overrun         (overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic pe, input logic fe, input logic ov);
    check({tag, "_parity_err"}, parity_err, pe);
    check({tag, "_frame_err"}, frame_err, fe);
    check({tag, "_overrun"}, overrun, ov);
  endtask

  task automatic idle_bits(input int n);
    repeat (n * int'(baud_divider)) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit with_par, input bit p, input bit stop);
    rx = 1'b0;
    repeat (baud_divider) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (baud_divider) @(negedge clk);
    end
    if (with_par) begin
      rx = p;
      repeat (baud_divider) @(negedge clk);
    end
    rx = stop;
    repeat (baud_divider) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic clear_errors();
    @(negedge clk) err_clear = 1'b1;
    @(negedge clk) err_clear = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < DEPTH + 2 && !buffer_empty; n++) begin
      if (exp_q.size() > 0) check({tag, "_data"}, data, exp_q.pop_front());
      @(negedge clk) re = 1'b1;
      @(negedge clk) re = 1'b0;
    end
    check({tag, "_empty"}, buffer_empty, 1'b1);
    check({tag, "_missing"}, exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_empty", buffer_empty, 1'b1);
    check("rst_full", buffer_full, 1'b0);
    check("rst_data", data, 8'h00);
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    idle_bits(2);

    // Good frame with exact latency: start-detect 3, half bit, 9 bits, then FIFO write
    exp_q.push_back(8'hA5);
    lat_cyc = 0;
    fork
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
      begin
        while (lat_cyc < 400 && buffer_empty) begin
          @(posedge clk);
          #1 lat_cyc++;
        end
        check("a5_latency", lat_cyc, 3 + 8 + 9 * 16 + 1);
      end
    join
    check_flags("a5", 1'b0, 1'b0, 1'b0);
    drain("a5");

    // Even parity: 0x37 has five ones so p=1 is good
    parity_en = 1'b1;
    parity_type_odd = 1'b0;
    exp_q.push_back(8'h37);
    send_frame(8'h37, 1'b1, 1'b1, 1'b1);
    idle_bits(1);
    drain("even_ok");
    send_frame(8'h37, 1'b1, 1'b0, 1'b1);
    idle_bits(1);
    check("even_bad_empty", buffer_empty, 1'b1);
    check_flags("even_bad", 1'b1, 1'b0, 1'b0);
    clear_errors();
    check("even_clr", parity_err, 1'b0);

    // Odd parity at div=8: 0xC8 has three ones so p=0 is good
    baud_divider = 12'd8;
    parity_type_odd = 1'b1;
    exp_q.push_back(8'hC8);
    send_frame(8'hC8, 1'b1, 1'b0, 1'b1);
    idle_bits(1);
    drain("odd_ok");
    send_frame(8'hC8, 1'b1, 1'b1, 1'b1);
    idle_bits(1);
    check("odd_bad", parity_err, 1'b1);
    clear_errors();
    baud_divider = 12'd16;
    parity_en = 1'b0;
    parity_type_odd = 1'b0;
    idle_bits(1);

    // Bad stop bit with err_clear landing on the set cycle: set wins
    fork
      send_frame(8'h55, 1'b0, 1'b0, 1'b0);
      begin
        repeat (155) @(posedge clk);
        @(negedge clk) err_clear = 1'b1;
        @(negedge clk) err_clear = 1'b0;
      end
    join
    idle_bits(1);
    check("stop0_empty", buffer_empty, 1'b1);
    check_flags("stop0", 1'b0, 1'b1, 1'b0);
    clear_errors();

    // Break: 40 bit times low gives one frame error only
    rx = 1'b0;
    idle_bits(15);
    check("brk_first", frame_err, 1'b1);
    clear_errors();
    idle_bits(25);
    check("brk_once", frame_err, 1'b0);
    rx = 1'b1;
    idle_bits(3);
    check("brk_after", frame_err, 1'b0);
    check("brk_empty", buffer_empty, 1'b1);

    // Short glitch is rejected at the start-bit centre
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    idle_bits(3);
    check("glitch_empty", buffer_empty, 1'b1);
    check_flags("glitch", 1'b0, 1'b0, 1'b0);

    // Overrun: fifth byte dropped when nobody reads
    for (int b = 1; b <= 5; b++) begin
      if (b <= DEPTH) exp_q.push_back(b[7:0]);
      send_frame(b[7:0], 1'b0, 1'b0, 1'b1);
    end
    idle_bits(1);
    check("ov_full", buffer_full, 1'b1);
    check_flags("ov", 1'b0, 1'b0, 1'b1);
    drain("ov");
    clear_errors();
    check("ov_clr", overrun, 1'b0);

    // Same again with a pop in the cycle the fifth byte is offered
    for (int b = 1; b <= 4; b++) begin
      exp_q.push_back(b[7:0]);
      send_frame(b[7:0], 1'b0, 1'b0, 1'b1);
    end
    exp_q.push_back(8'h05);
    fork
      send_frame(8'h05, 1'b0, 1'b0, 1'b1);
      begin
        repeat (155) @(posedge clk);
        @(negedge clk) re = 1'b1;
        check("ov2_head", data, exp_q.pop_front());
        @(negedge clk) re = 1'b0;
      end
    join
    idle_bits(1);
    check("ov2_full", buffer_full, 1'b1);
    check_flags("ov2", 1'b0, 1'b0, 1'b0);
    drain("ov2");

    // Reset mid-frame with a byte stored and a flag set
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0);
    idle_bits(1);
    check("pre_rst_empty", buffer_empty, 1'b0);
    check("pre_rst_ferr", frame_err, 1'b1);
    fork
      send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
      begin
        repeat (4 * 16 + 8) @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_empty", buffer_empty, 1'b1);
        check("mid_rst_full", buffer_full, 1'b0);
        check("mid_rst_data", data, 8'h00);
        check_flags("mid_rst", 1'b0, 1'b0, 1'b0);
        exp_q.delete();
      end
    join
    rx = 1'b0;
    @(negedge clk) rst = 1'b1;
    repeat (40) @(negedge clk);
    rx = 1'b1;
    idle_bits(3);
    check("low_rel_empty", buffer_empty, 1'b1);
    check_flags("low_rel", 1'b0, 1'b0, 1'b0);
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
    idle_bits(1);
    drain("c3");
    check_flags("end", 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
